// File: rtl/crop_filter_stream.sv
// Streaming crop stage: forwards only pixels inside a programmable window of a raster frame,
// tags them with frame/line markers and buffers them in a registered 2-entry skid buffer.
module crop_filter_stream #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int Y_1             = 10,
  parameter int X_1             = 10,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cfg_valid,
  input  logic [$clog2(IN_ROWS):0]            cfg_y1,
  input  logic [$clog2(IN_COLS):0]            cfg_x1,
  input  logic [$clog2(IN_ROWS):0]            cfg_rows,
  input  logic [$clog2(IN_COLS):0]            cfg_cols,
  input  logic [PIXEL_BIT_WIDTH*CHANNELS-1:0] pixel_in,
  input  logic                                in_sof,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [PIXEL_BIT_WIDTH*CHANNELS-1:0] pixel_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                out_eof,
  output logic                                frame_err
);

  localparam int YW = $clog2(IN_ROWS) + 1;
  localparam int XW = $clog2(IN_COLS) + 1;
  localparam int DW = PIXEL_BIT_WIDTH * CHANNELS;

  // state    | meaning
  // WAIT_SOF | between frames; beats without in_sof are dropped
  // ACTIVE   | inside a frame; x/y track the next expected coordinate
  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t state, state_nxt;
  logic [YW-1:0] y, y_nxt, act_y1, act_rows, pend_y1, pend_rows;
  logic [XW-1:0] x, x_nxt, act_x1, act_cols, pend_x1, pend_cols;
  logic err_set;

  logic          accept, live, in_win, push, pop;
  logic [YW-1:0] beat_y, win_y1, win_rows;
  logic [XW-1:0] beat_x, win_x1, win_cols;
  logic [YW:0]   y_sum, y_end;
  logic [XW:0]   x_sum, x_end;
  logic          mk_sof, mk_eol, mk_eof;

  logic [DW-1:0] tail_pix;
  logic          tail_sof, tail_eol, tail_eof, tail_valid, tail_valid_nxt;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign live   = in_sof | (state == ACTIVE);

  // A start-of-frame beat is evaluated against the pending window it is about to load.
  assign win_y1   = in_sof ? pend_y1   : act_y1;
  assign win_x1   = in_sof ? pend_x1   : act_x1;
  assign win_rows = in_sof ? pend_rows : act_rows;
  assign win_cols = in_sof ? pend_cols : act_cols;
  assign beat_y   = in_sof ? '0 : y;
  assign beat_x   = in_sof ? '0 : x;

  assign y_sum = {1'b0, win_y1} + {1'b0, win_rows};
  assign x_sum = {1'b0, win_x1} + {1'b0, win_cols};
  assign y_end = (y_sum > (YW+1)'(IN_ROWS)) ? (YW+1)'(IN_ROWS) : y_sum;
  assign x_end = (x_sum > (XW+1)'(IN_COLS)) ? (XW+1)'(IN_COLS) : x_sum;

  assign in_win = ({1'b0, beat_y} >= {1'b0, win_y1}) && ({1'b0, beat_y} < y_end) &&
                  ({1'b0, beat_x} >= {1'b0, win_x1}) && ({1'b0, beat_x} < x_end);
  assign push   = accept & live & in_win;

  assign mk_sof = (beat_y == win_y1) && (beat_x == win_x1);
  assign mk_eol = ({1'b0, beat_x} == x_end - (XW+1)'(1));
  assign mk_eof = ({1'b0, beat_y} == y_end - (YW+1)'(1)) && mk_eol;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    err_set   = 1'b0;
    if (accept && live) begin
      if (in_sof && (state == ACTIVE) && ((x != '0) || (y != '0)))
        err_set = 1'b1;
      state_nxt = ACTIVE;
      if (beat_x == XW'(IN_COLS - 1)) begin
        x_nxt = '0;
        if (beat_y == YW'(IN_ROWS - 1)) begin
          y_nxt     = '0;
          state_nxt = WAIT_SOF;
        end else begin
          y_nxt = beat_y + YW'(1);
        end
      end else begin
        x_nxt = beat_x + XW'(1);
        y_nxt = beat_y;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      frame_err <= 1'b0;
      act_y1    <= YW'(Y_1);
      act_x1    <= XW'(X_1);
      act_rows  <= YW'(OUT_ROWS);
      act_cols  <= XW'(OUT_COLS);
      pend_y1   <= YW'(Y_1);
      pend_x1   <= XW'(X_1);
      pend_rows <= YW'(OUT_ROWS);
      pend_cols <= XW'(OUT_COLS);
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      if (err_set)
        frame_err <= 1'b1;
      if (cfg_valid) begin
        pend_y1   <= cfg_y1;
        pend_x1   <= cfg_x1;
        pend_rows <= cfg_rows;
        pend_cols <= cfg_cols;
      end
      if (accept && in_sof) begin
        act_y1   <= pend_y1;
        act_x1   <= pend_x1;
        act_rows <= pend_rows;
        act_cols <= pend_cols;
      end
    end
  end

  // Push never coincides with a full buffer because in_ready already mirrors !tail_valid.
  always_comb begin
    tail_valid_nxt = tail_valid;
    if (tail_valid)
      tail_valid_nxt = !(pop && !push);
    else
      tail_valid_nxt = push && !pop && out_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      tail_valid <= 1'b0;
      tail_pix   <= '0;
      tail_sof   <= 1'b0;
      tail_eol   <= 1'b0;
      tail_eof   <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      tail_valid <= tail_valid_nxt;
      in_ready   <= !tail_valid_nxt;
      case ({push, pop})
        2'b10: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            pixel_out <= pixel_in;
            out_sof   <= mk_sof;
            out_eol   <= mk_eol;
            out_eof   <= mk_eof;
          end else begin
            tail_pix <= pixel_in;
            tail_sof <= mk_sof;
            tail_eol <= mk_eol;
            tail_eof <= mk_eof;
          end
        end
        2'b01: begin
          if (tail_valid) begin
            pixel_out <= tail_pix;
            out_sof   <= tail_sof;
            out_eol   <= tail_eol;
            out_eof   <= tail_eof;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (tail_valid) begin
            pixel_out <= tail_pix;
            out_sof   <= tail_sof;
            out_eol   <= tail_eol;
            out_eof   <= tail_eof;
            tail_pix  <= pixel_in;
            tail_sof  <= mk_sof;
            tail_eol  <= mk_eol;
            tail_eof  <= mk_eof;
          end else begin
            pixel_out <= pixel_in;
            out_sof   <= mk_sof;
            out_eol   <= mk_eol;
            out_eof   <= mk_eof;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_filter_stream.sv
// Scoreboard bench for crop_filter_stream: a window model predicts every cropped beat,
// a negedge monitor compares pops, handshake flags and stall stability.
module tb_crop_filter_stream;

  typedef struct {
    logic [11:0] pix;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [6:0]  cfg_y1 = '0, cfg_x1 = '0, cfg_rows = '0, cfg_cols = '0;
  logic [11:0] pixel_in = '0;
  logic        in_sof = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_sof, out_eol, out_eof, frame_err;
  logic [11:0] pixel_out;

  crop_filter_stream dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid),
    .cfg_y1(cfg_y1), .cfg_x1(cfg_x1), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .pixel_in(pixel_in), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int   vectors = 0, miscompares = 0;
  exp_t q[$];
  bit   check_en = 0;
  int   rdy_mode = 0;
  bit   gap_en = 0;
  int   pops = 0;
  exp_t first_pop, last_pop;

  // window model
  int p_y1 = 10, p_x1 = 10, p_rows = 20, p_cols = 20;
  int a_y1 = 10, a_x1 = 10, a_rows = 20, a_cols = 20;
  int mx = 0, my = 0;
  bit m_active = 0, exp_err = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) == 0);
      default: out_ready = 1'b0;
    endcase
  end

  bit          stall_prev = 0;
  logic [11:0] hold_pix;
  logic [2:0]  hold_mk;
  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (out_valid !== (q.size() > 0)) begin
        miscompares++;
        $display("FAIL out_valid: got %b expected %b (queued %0d)", out_valid, q.size() > 0, q.size());
      end
      vectors++;
      if (in_ready !== (q.size() < 2)) begin
        miscompares++;
        $display("FAIL in_ready: got %b expected %b (queued %0d)", in_ready, q.size() < 2, q.size());
      end
      if (stall_prev) begin
        vectors++;
        if (pixel_out !== hold_pix || {out_sof, out_eol, out_eof} !== hold_mk) begin
          miscompares++;
          $display("FAIL stall_hold: got %0d/%b expected %0d/%b", pixel_out,
                   {out_sof, out_eol, out_eof}, hold_pix, hold_mk);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got %0d expected none", pixel_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (pixel_out !== e.pix || out_sof !== e.sof || out_eol !== e.eol || out_eof !== e.eof) begin
            miscompares++;
            $display("FAIL beat: got %0d sof%b eol%b eof%b expected %0d sof%b eol%b eof%b",
                     pixel_out, out_sof, out_eol, out_eof, e.pix, e.sof, e.eol, e.eof);
          end
        end
        if (pops == 0) first_pop = '{pixel_out, out_sof, out_eol, out_eof};
        last_pop = '{pixel_out, out_sof, out_eol, out_eof};
        pops++;
      end
      stall_prev = out_valid && !out_ready;
      hold_pix   = pixel_out;
      hold_mk    = {out_sof, out_eol, out_eof};
    end else begin
      stall_prev = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic cfg(input int y1, input int x1, input int rows, input int cols);
    cfg_valid = 1'b1;
    cfg_y1 = 7'(y1); cfg_x1 = 7'(x1); cfg_rows = 7'(rows); cfg_cols = 7'(cols);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    p_y1 = y1; p_x1 = x1; p_rows = rows; p_cols = cols;
  endtask

  task automatic send_beat(input int pix, input bit sof);
    bit acc;
    int bx, by, yend, xend;
    acc = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    pixel_in = 12'(pix);
    in_sof   = sof;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept of %0d", pix);
      return;
    end
    if (sof) begin
      if (m_active && (mx != 0 || my != 0)) exp_err = 1;
      a_y1 = p_y1; a_x1 = p_x1; a_rows = p_rows; a_cols = p_cols;
      bx = 0; by = 0; m_active = 1;
    end else if (!m_active) begin
      return;
    end else begin
      bx = mx; by = my;
    end
    yend = (a_y1 + a_rows > 40) ? 40 : a_y1 + a_rows;
    xend = (a_x1 + a_cols > 40) ? 40 : a_x1 + a_cols;
    if (by >= a_y1 && by < yend && bx >= a_x1 && bx < xend)
      q.push_back('{12'(pix), (by == a_y1 && bx == a_x1), (bx == xend - 1),
                    (by == yend - 1 && bx == xend - 1)});
    if (bx == 39) begin
      mx = 0;
      if (by == 39) begin my = 0; m_active = 0; end
      else my = by + 1;
    end else begin
      mx = bx + 1; my = by;
    end
  endtask

  task automatic send_frame(input bit mid_cfg, input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      if (mid_cfg && i == 20 * 40) cfg(10, 30, 20, 20);
      send_beat(i, i == 0);
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 4000 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string name, input int expected);
    vectors++;
    if (pops !== expected) begin
      miscompares++;
      $display("FAIL %s_count: got %0d expected %0d", name, pops, expected);
    end
    vectors++;
    if (frame_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s_frame_err: got %b expected %b", name, frame_err, exp_err);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #23;
    vectors++;
    if (out_valid !== 1'b0 || pixel_out !== 12'd0 || {out_sof, out_eol, out_eof} !== 3'b000 ||
        frame_err !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v%b p%0d mk%b err%b rdy%b expected all zero",
               out_valid, pixel_out, {out_sof, out_eol, out_eof}, frame_err, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_high: got %b expected 1", in_ready);
    end
    check_en = 1;
  endtask

  task automatic test_frame;
    pops = 0;
    send_frame(0, 1600);
    drain("frame");
    check_count("frame", 400);
    vectors++;
    if (first_pop.pix !== 12'd410 || first_pop.sof !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_first: got %0d sof%b expected 410 sof1", first_pop.pix, first_pop.sof);
    end
    vectors++;
    if (last_pop.pix !== 12'd1189 || last_pop.eof !== 1'b1 || last_pop.eol !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_last: got %0d eol%b eof%b expected 1189 eol1 eof1",
               last_pop.pix, last_pop.eol, last_pop.eof);
    end
  endtask

  task automatic test_stall;
    pops = 0;
    rdy_mode = 1;
    gap_en = 1;
    send_frame(0, 1600);
    rdy_mode = 0;
    gap_en = 0;
    drain("stall");
    check_count("stall", 400);
  endtask

  task automatic test_cfg_midframe;
    pops = 0;
    send_frame(1, 1600);
    drain("cfg_cur");
    check_count("cfg_cur", 400);
    pops = 0;
    send_frame(0, 1600);
    drain("cfg_next");
    check_count("cfg_next", 200);
    vectors++;
    if (last_pop.pix !== 12'd1199 || !last_pop.eof) begin
      miscompares++;
      $display("FAIL cfg_next_last: got %0d eof%b expected 1199 eof1", last_pop.pix, last_pop.eof);
    end
    cfg(10, 10, 20, 20);
  endtask

  task automatic test_drop_and_err;
    pops = 0;
    for (int i = 0; i < 5; i++) send_beat(100 + i, 0);
    send_frame(0, 1600);
    drain("drop");
    check_count("drop", 400);
    pops = 0;
    send_frame(0, 12 * 40 + 5);
    send_frame(0, 1600);
    drain("err");
    check_count("err", 440);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b expected 1", frame_err);
    end
  endtask

  task automatic test_empty_and_corner;
    pops = 0;
    cfg(10, 10, 0, 20);
    send_frame(0, 1600);
    drain("empty");
    check_count("empty", 0);
    pops = 0;
    cfg(39, 39, 1, 1);
    send_frame(0, 1600);
    drain("corner");
    check_count("corner", 1);
    vectors++;
    if (last_pop.pix !== 12'd1599 || {last_pop.sof, last_pop.eol, last_pop.eof} !== 3'b111) begin
      miscompares++;
      $display("FAIL corner_beat: got %0d mk%b expected 1599 mk111", last_pop.pix,
               {last_pop.sof, last_pop.eol, last_pop.eof});
    end
    cfg(10, 10, 20, 20);
  endtask

  task automatic test_reset_mid;
    send_frame(0, 15 * 40 + 14);
    drain("pre_reset");
    rdy_mode = 2;
    out_ready = 1'b0;
    send_beat(15 * 40 + 14, 0);
    send_beat(15 * 40 + 15, 0);
    vectors++;
    if (q.size() != 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_full: got queued %0d ready %b expected 2 and 0", q.size(), in_ready);
    end
    check_en = 0;
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || pixel_out !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_mid_flush: got v%b p%0d expected v0 p0", out_valid, pixel_out);
    end
    q.delete();
    m_active = 0; mx = 0; my = 0; exp_err = 0;
    p_y1 = 10; p_x1 = 10; p_rows = 20; p_cols = 20;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 0;
    out_ready = 1'b1;
    check_en = 1;
    repeat (5) @(posedge clk);
    #1;
    pops = 0;
    send_frame(0, 1600);
    drain("post_reset");
    check_count("post_reset", 400);
    vectors++;
    if (first_pop.pix !== 12'd410 || last_pop.pix !== 12'd1189) begin
      miscompares++;
      $display("FAIL post_reset_ends: got %0d..%0d expected 410..1189", first_pop.pix, last_pop.pix);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_stall;
    test_cfg_midframe;
    test_drop_and_err;
    test_empty_and_corner;
    test_reset_mid;
    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
